// File: rtl/timed_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one waveform-memory write port between NUM_CH
// timed_fifo channels. Each channel has a small pending queue. A push into a
// full queue that is not popped in the same cycle is dropped and raises a
// sticky overflow flag for that channel.
module timed_fifo_wr_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 18,
    parameter int ADDR_W     = 11,
    parameter int PEND_DEPTH = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CH-1:0]                         ch_wr_en,
    input  logic [NUM_CH*DATA_W-1:0]                  ch_data,
    input  logic [NUM_CH*ADDR_W-1:0]                  ch_addr,
    input  logic                                      mem_stall,
    input  logic                                      clear_err,
    output logic                                      mem_wr_en,
    output logic [DATA_W-1:0]                         mem_wr_data,
    output logic [ADDR_W-1:0]                         mem_wr_addr,
    output logic [$clog2(NUM_CH)-1:0]                 mem_wr_ch,
    output logic [NUM_CH*($clog2(PEND_DEPTH)+1)-1:0]  pend_cnt,
    output logic [NUM_CH-1:0]                         overflow
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0]  r_mem    [NUM_CH][PEND_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [NUM_CH-1:0] r_overflow;
    logic [CH_W-1:0]   r_rr;

    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_ch;
    logic [ENT_W-1:0]  w_head;
    int                w_idx;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_drop;

    // Round-robin search over registered non-empty flags, starting at the pointer
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = 0;
        if (!mem_stall) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_idx = int'(r_rr) + k;
                if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
                if (!w_gnt_vld && (r_cnt[w_idx] != '0)) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_ch  = CH_W'(w_idx);
                end
            end
        end
        w_head = r_mem[w_gnt_ch][r_rd_ptr[w_gnt_ch]];
    end

    // Per-channel push/pop decode; a pop frees the slot a full-queue push needs
    always_comb begin
        w_pop    = '0;
        w_full   = '0;
        w_accept = '0;
        w_drop   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop[i]    = w_gnt_vld && (w_gnt_ch == CH_W'(i));
            w_full[i]   = (r_cnt[i] == CNT_W'(PEND_DEPTH));
            w_accept[i] = ch_wr_en[i] && (!w_full[i] || w_pop[i]);
            w_drop[i]   = ch_wr_en[i] && w_full[i] && !w_pop[i];
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset && w_accept[i]) begin
                r_mem[i][r_wr_ptr[i]] <= {ch_addr[i*ADDR_W +: ADDR_W],
                                          ch_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Queue pointers and occupancy counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end else begin
                if (w_accept[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                if (w_pop[i])    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                if (w_accept[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (!w_accept[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    // Sticky overflow flags and round-robin pointer; a new drop beats clear_err
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= '0;
            r_rr       <= '0;
        end else begin
            r_overflow <= (clear_err ? '0 : r_overflow) | w_drop;
            if (w_gnt_vld) begin
                r_rr <= (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + CH_W'(1);
            end
        end
    end

    // Output register: strobe every edge, payload held when there is no grant
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mem_wr_addr <= '0;
            mem_wr_ch   <= '0;
        end else begin
            mem_wr_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                mem_wr_data <= w_head[DATA_W-1:0];
                mem_wr_addr <= w_head[ENT_W-1:DATA_W];
                mem_wr_ch   <= w_gnt_ch;
            end
        end
    end

    // Flatten per-channel occupancy onto the packed output
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign overflow = r_overflow;

endmodule
